gfx_rom_loader: RTL and testbench

// - Writer end of the graphics EPROM download port: turns the ioctl download stream into
//   per-chip write strobes (addr/data/wr/cs) for the NUM_ROMS tile-layer eprom_32 instances.
// - Sits between the HPS ioctl bus and the tile-layer boards, on sys_clk.
// - Tracks download progress, completeness and ordering errors for the top level.

---
 rtl/gfx_rom_loader_pkg.sv | 12 +
 rtl/gfx_rom_loader_if.sv | 28 ++
 rtl/gfx_loader_decode.sv | 29 ++
 rtl/gfx_rom_loader.sv | 150 +++++++++++++++
 tb/tb_gfx_rom_loader.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gfx_rom_loader_pkg.sv
// Shared types for the graphics EPROM loader: FSM state encoding and default download index.
package m72_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } loader_state_e;

  localparam logic [7:0] GFX_INDEX_DEFAULT = 8'd0;

endpackage

// File: rtl/gfx_rom_loader_if.sv
// ioctl download bus in, per-chip EPROM write strobes out.
// master: HPS/top-level side; slave: the loader.
interface gfx_rom_loader_if #(
  parameter int unsigned ROM_AW   = 15,
  parameter int unsigned NUM_ROMS = 4
);

  logic                ioctl_download;
  logic [7:0]          ioctl_index;
  logic                ioctl_wr;
  logic [24:0]         ioctl_addr;
  logic [7:0]          ioctl_dout;
  logic [ROM_AW-1:0]   rom_addr;
  logic [7:0]          rom_data;
  logic                rom_wr;
  logic [NUM_ROMS-1:0] rom_cs;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  rom_addr, rom_data, rom_wr, rom_cs
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output rom_addr, rom_data, rom_wr, rom_cs
  );

endinterface

// File: rtl/gfx_loader_decode.sv
// Address decode for the loader window: hit test, byte offset, chip select index and
// in-chip address, all purely combinational from the ioctl byte address.
module gfx_loader_decode #(
  parameter logic [24:0] GFX_BASE = 25'h000000,
  parameter int unsigned NUM_ROMS = 4,
  parameter int unsigned ROM_AW   = 15
) (
  input  logic [24:0]                         addr,
  output logic                                hit,
  output logic [ROM_AW+$clog2(NUM_ROMS)-1:0]  offset,
  output logic [$clog2(NUM_ROMS)-1:0]         chip,
  output logic [ROM_AW-1:0]                   rom_addr
);

  localparam int unsigned CW = $clog2(NUM_ROMS);
  localparam int unsigned OW = ROM_AW + CW;

  logic [24:0] diff;

  // Window is exactly 2^OW bytes, so "below the top" is "upper offset bits all zero".
  always_comb begin
    diff     = addr - GFX_BASE;
    hit      = (addr >= GFX_BASE) && (diff[24:OW] == '0);
    offset   = diff[OW-1:0];
    chip     = diff[ROM_AW +: CW];
    rom_addr = diff[ROM_AW-1:0];
  end

endmodule

// File: rtl/gfx_rom_loader.sv
// Graphics EPROM download writer: turns the ioctl stream into per-chip write strobes and
// tracks progress, completeness and ordering errors.
// Optional feature: define GFX_LOADER_CHECKSUM_EN to add a 16-bit running byte checksum port.
module gfx_rom_loader
  import m72_loader_pkg::*;
#(
  parameter logic [7:0]  GFX_INDEX = GFX_INDEX_DEFAULT,
  parameter logic [24:0] GFX_BASE  = 25'h000000,
  parameter int unsigned NUM_ROMS  = 4,
  parameter int unsigned ROM_AW    = 15
) (
  input  logic                                sys_clk,
  input  logic                                reset,
  gfx_rom_loader_if.slave                     bus,
  output logic                                load_busy,
  output logic                                load_done,
  output logic                                load_error,
  output logic [ROM_AW+$clog2(NUM_ROMS):0]    bytes_loaded
`ifdef GFX_LOADER_CHECKSUM_EN
  ,
  output logic [15:0]                         checksum
`endif
);

  localparam int unsigned CW = $clog2(NUM_ROMS);
  localparam int unsigned OW = ROM_AW + CW;
  localparam int unsigned BW = OW + 1;
  localparam logic [BW-1:0] TOTAL = {1'b1, {OW{1'b0}}};

  loader_state_e state_q, state_d;

  logic                download_q;
  logic                hit;
  logic [OW-1:0]       offset;
  logic [CW-1:0]       chip;
  logic [ROM_AW-1:0]   dec_addr;
  logic                rise, fall, idx_match, start, accept, ord_err, finish, clean;
  logic [BW-1:0]       cnt_q, cnt_nx;
  logic [OW-1:0]       exp_q;
  logic                done_q, err_q;
  logic [NUM_ROMS-1:0] cs_dec;
  logic [ROM_AW-1:0]   rom_addr_q;
  logic [7:0]          rom_data_q;
  logic                rom_wr_q;
  logic [NUM_ROMS-1:0] rom_cs_q;

  gfx_loader_decode #(
    .GFX_BASE (GFX_BASE),
    .NUM_ROMS (NUM_ROMS),
    .ROM_AW   (ROM_AW)
  ) u_decode (
    .addr     (bus.ioctl_addr),
    .hit      (hit),
    .offset   (offset),
    .chip     (chip),
    .rom_addr (dec_addr)
  );

  // Download edge detection, byte acceptance and end-of-download cleanliness.
  always_comb begin
    rise      = bus.ioctl_download & ~download_q;
    fall      = ~bus.ioctl_download & download_q;
    idx_match = (bus.ioctl_index == GFX_INDEX);
    start     = rise & idx_match & (state_q != LOAD);
    // Acceptance does not require download high: a byte on the falling edge still counts.
    accept    = (state_q == LOAD) & bus.ioctl_wr & idx_match & hit;
    ord_err   = accept & (offset != exp_q);
    cnt_nx    = (accept && (cnt_q != '1)) ? cnt_q + BW'(1) : cnt_q;
    finish    = (state_q == LOAD) & fall;
    clean     = (cnt_nx == TOTAL) & ~err_q & ~ord_err;
    cs_dec    = '0;
    cs_dec[chip] = 1'b1;
  end

  // FSM state register.
  always_ff @(posedge sys_clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start)  state_d = LOAD;
      LOAD:       if (finish) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // FSM and datapath outputs.
  always_comb begin
    load_busy    = (state_q == LOAD);
    load_done    = done_q;
    load_error   = err_q;
    bytes_loaded = cnt_q;
    bus.rom_addr = rom_addr_q;
    bus.rom_data = rom_data_q;
    bus.rom_wr   = rom_wr_q;
    bus.rom_cs   = rom_cs_q;
  end

  // Write strobe pipeline, progress counter, expected offset and sticky flags.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      // Treat download as already high so a download active at release is ignored.
      download_q <= 1'b1;
      rom_wr_q   <= 1'b0;
      rom_cs_q   <= '0;
      rom_addr_q <= '0;
      rom_data_q <= '0;
      cnt_q      <= '0;
      exp_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      download_q <= bus.ioctl_download;
      rom_wr_q   <= accept;
      rom_cs_q   <= accept ? cs_dec : '0;
      if (accept) begin
        rom_addr_q <= dec_addr;
        rom_data_q <= bus.ioctl_dout;
        exp_q      <= offset + OW'(1);
      end
      if (start) begin
        cnt_q  <= '0;
        exp_q  <= '0;
        done_q <= 1'b0;
        err_q  <= 1'b0;
      end else begin
        cnt_q  <= cnt_nx;
        done_q <= done_q | (finish & clean);
        err_q  <= err_q | ord_err | (finish & ~clean);
      end
    end
  end

`ifdef GFX_LOADER_CHECKSUM_EN
  logic [15:0] sum_q;

  // Wrapping byte sum, updated alongside the byte count.
  always_ff @(posedge sys_clk) begin
    if (reset || start) sum_q <= '0;
    else if (accept)    sum_q <= sum_q + {8'h00, bus.ioctl_dout};
  end

  assign checksum = sum_q;
`endif

endmodule

// File: tb/tb_gfx_rom_loader.sv
// Bench for gfx_rom_loader: directed scenarios plus randomized downloads, every cycle
// compared against a behavioural model of the download rules.
module tb_gfx_rom_loader;

  localparam logic [7:0]  IDX   = 8'h03;
  localparam logic [24:0] BASE  = 25'h004000;
  localparam int          NR    = 4;
  localparam int          AW    = 11;
  localparam int          ROMSZ = 1 << AW;
  localparam int          TOTAL = NR * ROMSZ;
  localparam int          BW    = AW + 2 + 1;
  localparam int          MAXC  = (1 << BW) - 1;

  logic          sys_clk = 1'b0;
  logic          reset;
  logic          load_busy, load_done, load_error;
  logic [BW-1:0] bytes_loaded;
`ifdef GFX_LOADER_CHECKSUM_EN
  logic [15:0]   checksum;
`endif

  gfx_rom_loader_if #(.ROM_AW(AW), .NUM_ROMS(NR)) bus ();

  gfx_rom_loader #(
    .GFX_INDEX (IDX),
    .GFX_BASE  (BASE),
    .NUM_ROMS  (NR),
    .ROM_AW    (AW)
  ) dut (
    .sys_clk      (sys_clk),
    .reset        (reset),
    .bus          (bus),
    .load_busy    (load_busy),
    .load_done    (load_done),
    .load_error   (load_error),
    .bytes_loaded (bytes_loaded)
`ifdef GFX_LOADER_CHECKSUM_EN
    ,
    .checksum     (checksum)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  // Model of what the outputs must be after each clock edge.
  bit          m_prev_dl, m_active, m_err, m_done;
  int          m_count, m_next;
  logic        m_wr;
  logic [3:0]  m_cs;
  logic [AW-1:0] m_addr;
  logic [7:0]  m_data;
  logic [15:0] m_sum;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;
  bit dl_lvl   = 1;
  int chip_cnt [NR];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model(input bit rst, input bit dl, input logic [7:0] idx, input bit w,
                       input logic [24:0] a, input logic [7:0] d);
    int off;
    bit rise, fall, hit;
    if (rst) begin
      m_prev_dl = 1; m_active = 0; m_err = 0; m_done = 0; m_count = 0; m_next = 0;
      m_wr = 0; m_cs = 0; m_addr = 0; m_data = 0; m_sum = 0;
      return;
    end
    rise = dl && !m_prev_dl;
    fall = !dl && m_prev_dl;
    m_prev_dl = dl;
    m_wr = 0;
    m_cs = 0;
    hit = (int'(a) >= int'(BASE)) && (int'(a) < int'(BASE) + TOTAL);
    if (m_active) begin
      if (w && idx == IDX && hit) begin
        off    = int'(a) - int'(BASE);
        m_wr   = 1;
        m_cs   = 4'(1 << (off / ROMSZ));
        m_addr = AW'(off % ROMSZ);
        m_data = d;
        if (off != m_next) m_err = 1;
        m_next = (off + 1) % TOTAL;
        if (m_count < MAXC) m_count++;
        m_sum = m_sum + {8'h00, d};
      end
      if (fall) begin
        m_active = 0;
        if (m_count == TOTAL && !m_err) m_done = 1;
        else m_err = 1;
      end
    end else if (rise && idx == IDX) begin
      m_active = 1; m_count = 0; m_next = 0; m_err = 0; m_done = 0; m_sum = 0;
    end
  endtask

  task automatic step(input bit rst, input bit dl, input logic [7:0] idx, input bit w,
                      input logic [24:0] a, input logic [7:0] d);
    reset              = rst;
    bus.ioctl_download = dl;
    bus.ioctl_index    = idx;
    bus.ioctl_wr       = w;
    bus.ioctl_addr     = a;
    bus.ioctl_dout     = d;
    @(posedge sys_clk);
    model(rst, dl, idx, w, a, d);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, dl_lvl, IDX, 0, BASE, 8'h00);
  endtask

  task automatic wb(input int off, input logic [7:0] d);
    step(0, dl_lvl, IDX, 1, BASE + 25'(off), d);
  endtask

  task automatic start_load();
    dl_lvl = 0; idle(1);
    dl_lvl = 1; idle(1);
  endtask

  task automatic end_load();
    dl_lvl = 0; idle(1);
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge sys_clk) begin
    if (chk_en) begin
      chk("rom_wr", 32'(bus.rom_wr), 32'(m_wr));
      chk("rom_cs", 32'(bus.rom_cs), 32'(m_cs));
      chk("rom_addr", 32'(bus.rom_addr), 32'(m_addr));
      chk("rom_data", 32'(bus.rom_data), 32'(m_data));
      chk("load_busy", 32'(load_busy), 32'(m_active));
      chk("load_done", 32'(load_done), 32'(m_done));
      chk("load_error", 32'(load_error), 32'(m_err));
      chk("bytes_loaded", 32'(bytes_loaded), m_count);
`ifdef GFX_LOADER_CHECKSUM_EN
      chk("checksum", 32'(checksum), 32'(m_sum));
`endif
      if (bus.rom_wr === 1'b1) begin
        case (bus.rom_cs)
          4'b0001: chip_cnt[0]++;
          4'b0010: chip_cnt[1]++;
          4'b0100: chip_cnt[2]++;
          4'b1000: chip_cnt[3]++;
          default: ;
        endcase
      end
    end
  end

  initial begin
    logic [7:0]  sidx, idx;
    logic [24:0] a;
    int len, sel, off, nxt;
    bit w, rst, dl;

    // Reset with download held high: it must be ignored after release.
    step(1, 1, IDX, 0, BASE, 8'h00);
    step(1, 1, IDX, 0, BASE, 8'h00);
    chk_en = 1;
    chk("reset_rom_wr", 32'(bus.rom_wr), 0);
    chk("reset_rom_cs", 32'(bus.rom_cs), 0);
    chk("reset_rom_addr", 32'(bus.rom_addr), 0);
    chk("reset_busy", 32'(load_busy), 0);
    chk("reset_done", 32'(load_done), 0);
    chk("reset_error", 32'(load_error), 0);
    chk("reset_bytes", 32'(bytes_loaded), 0);
    dl_lvl = 1;
    wb(0, 8'h11); wb(1, 8'h22); idle(1);
    chk("held_dl_busy", 32'(load_busy), 0);
    chk("held_dl_bytes", 32'(bytes_loaded), 0);
    end_load();

    // Full sequential download.
    for (int i = 0; i < NR; i++) chip_cnt[i] = 0;
    start_load();
    chk("start_busy", 32'(load_busy), 1);
    for (int i = 0; i < TOTAL; i++) wb(i, 8'($urandom));
    end_load();
    idle(1);
    chk("full_done", 32'(load_done), 1);
    chk("full_error", 32'(load_error), 0);
    chk("full_bytes", 32'(bytes_loaded), TOTAL);
    chk("full_busy", 32'(load_busy), 0);
    for (int i = 0; i < NR; i++) chk("full_chip_strobes", chip_cnt[i], ROMSZ);

    // Byte at chip 1, address 5.
    start_load();
    wb(ROMSZ + 5, 8'hA5);
    chk("c1_wr", 32'(bus.rom_wr), 1);
    chk("c1_cs", 32'(bus.rom_cs), 32'b0010);
    chk("c1_addr", 32'(bus.rom_addr), 5);
    chk("c1_data", 32'(bus.rom_data), 32'hA5);
    idle(1);
    chk("c1_wr_one_cycle", 32'(bus.rom_wr), 0);
    chk("c1_cs_clear", 32'(bus.rom_cs), 0);
    chk("c1_addr_hold", 32'(bus.rom_addr), 5);
    end_load();

    // Cut after 1000 bytes; the last byte arrives on the falling edge.
    start_load();
    for (int i = 0; i < 999; i++) wb(i, 8'($urandom));
    dl_lvl = 0;
    wb(999, 8'h77);
    idle(1);
    chk("cut_bytes", 32'(bytes_loaded), 1000);
    chk("cut_error", 32'(load_error), 1);
    chk("cut_done", 32'(load_done), 0);

    // Skipped offset 0x10.
    start_load();
    for (int i = 0; i <= 16'h0F; i++) wb(i, 8'(i));
    wb(16'h11, 8'h5C);
    chk("skip_wr", 32'(bus.rom_wr), 1);
    chk("skip_addr", 32'(bus.rom_addr), 32'h11);
    chk("skip_data", 32'(bus.rom_data), 32'h5C);
    end_load();
    chk("skip_error", 32'(load_error), 1);
    chk("skip_done", 32'(load_done), 0);
    chk("skip_bytes", 32'(bytes_loaded), 17);

    // Rising edge with another index leaves DONE flags alone.
    step(0, 1, 8'h07, 0, BASE, 8'h00);
    step(0, 1, 8'h07, 1, BASE, 8'h33);
    chk("other_idx_busy", 32'(load_busy), 0);
    chk("other_idx_error", 32'(load_error), 1);
    chk("other_idx_bytes", 32'(bytes_loaded), 17);
    step(0, 0, 8'h07, 0, BASE, 8'h00);

    // Ignored writes inside LOAD: wrong index, beyond window, below base.
    start_load();
    step(0, 1, 8'h07, 1, BASE, 8'h44);
    chk("wrong_idx_wr", 32'(bus.rom_wr), 0);
    step(0, 1, IDX, 1, BASE + 25'(TOTAL), 8'h45);
    chk("beyond_wr", 32'(bus.rom_wr), 0);
    step(0, 1, IDX, 1, BASE - 25'd1, 8'h46);
    chk("below_wr", 32'(bus.rom_wr), 0);
    chk("ignored_bytes", 32'(bytes_loaded), 0);
    chk("ignored_error", 32'(load_error), 0);
    end_load();

    // Counter saturation.
    start_load();
    for (int i = 0; i < 2 * TOTAL + 5; i++) wb(i % TOTAL, 8'($urandom));
    end_load();
    chk("sat_bytes", 32'(bytes_loaded), MAXC);
    chk("sat_error", 32'(load_error), 1);

    // Reset mid-LOAD with download held high, including a write on the reset edge.
    start_load();
    wb(0, 8'h01); wb(1, 8'h02); wb(2, 8'h03);
    step(1, 1, IDX, 1, BASE + 25'd3, 8'h04);
    chk("rst_wr", 32'(bus.rom_wr), 0);
    chk("rst_cs", 32'(bus.rom_cs), 0);
    chk("rst_busy", 32'(load_busy), 0);
    chk("rst_bytes", 32'(bytes_loaded), 0);
    chk("rst_error", 32'(load_error), 0);
    wb(3, 8'h04); wb(4, 8'h05);
    chk("post_rst_wr", 32'(bus.rom_wr), 0);
    chk("post_rst_bytes", 32'(bytes_loaded), 0);
    end_load();
    start_load();
    wb(0, 8'h01); wb(1, 8'h02); wb(2, 8'hFF);
    idle(1);
    chk("sum_bytes", 32'(bytes_loaded), 3);
`ifdef GFX_LOADER_CHECKSUM_EN
    chk("checksum_literal", 32'(checksum), 32'h0102);
`endif
    end_load();

    // Randomized downloads.
    for (int r = 0; r < 25; r++) begin
      sidx = ($urandom_range(3) == 0) ? 8'($urandom) : IDX;
      step(0, 0, sidx, 0, BASE, 8'h00);
      step(0, 1, sidx, 0, BASE, 8'h00);
      len = $urandom_range(300, 20);
      nxt = 0;
      for (int c = 0; c < len; c++) begin
        sel = $urandom_range(99);
        w   = ($urandom_range(99) < 65);
        idx = sidx;
        off = nxt;
        if (sel < 5) off = (nxt + 1 + $urandom_range(7)) % TOTAL;
        a = BASE + 25'(off);
        if (sel >= 5 && sel < 9)   a = BASE + 25'(TOTAL + $urandom_range(100));
        if (sel >= 9 && sel < 12)  a = BASE - 25'(1 + $urandom_range(50));
        if (sel >= 12 && sel < 15) idx = sidx ^ 8'h40;
        if (w) nxt = (off + 1) % TOTAL;
        rst = ($urandom_range(499) == 0);
        dl  = (c != len - 1);
        step(rst, dl, idx, w, a, 8'($urandom));
      end
      step(0, 0, sidx, 0, BASE, 8'h00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
